// File: rtl/ramif2axi.sv
// ramif2axi: bridges a simple single-request RAM-style port onto an AXI4
// master. Each accepted request becomes exactly one single-beat AXI
// transaction; completion is reported with a one-cycle done pulse and an
// error pulse in the same cycle.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ram_addr/wdata/wstrb    request payload, captured on acceptance
//   ram_wr, ram_rd          request strobes (write wins when both are high)
//   ram_ready               high only while idle; request accepted when set
//   ram_rdata               last completed read data, held until next read
//   ram_rvalid, ram_wdone   one-cycle completion pulses
//   ram_err                 error pulse alongside ram_rvalid/ram_wdone
//   aw*/w*/b*, ar*/r*       AXI4 master write and read channels
module ramif2axi #(
  parameter int unsigned AWID      = 32,
  parameter int unsigned IDWID     = 4,
  parameter int unsigned DWID      = 64,
  parameter int unsigned WSTRB     = DWID/8,
  parameter int unsigned MASTER_ID = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWID-1:0]   ram_addr,
  input  logic [DWID-1:0]   ram_wdata,
  input  logic [WSTRB-1:0]  ram_wstrb,
  input  logic              ram_wr,
  input  logic              ram_rd,
  output logic              ram_ready,
  output logic [DWID-1:0]   ram_rdata,
  output logic              ram_rvalid,
  output logic              ram_wdone,
  output logic              ram_err,
  output logic [IDWID-1:0]  awid,
  output logic [AWID-1:0]   awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DWID-1:0]   wdata,
  output logic [WSTRB-1:0]  wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [IDWID-1:0]  bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [IDWID-1:0]  arid,
  output logic [AWID-1:0]   araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [IDWID-1:0]  rid,
  input  logic [DWID-1:0]   rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  typedef enum logic [2:0] {IDLE, WREQ, WRESP, RREQ, RDATA} state_t;

  localparam logic [2:0]       AXSIZE = 3'($clog2(WSTRB));
  localparam logic [IDWID-1:0] MID    = IDWID'(MASTER_ID);

  state_t state, state_nxt;

  logic accept_wr, accept_rd;
  logic aw_pending, w_pending;
  logic b_hs, r_hs;

  assign accept_wr = (state == IDLE) && ram_wr;
  assign accept_rd = (state == IDLE) && !ram_wr && ram_rd;

  // A write channel still owes a handshake only while its valid is high
  // and the slave is not taking it this cycle.
  assign aw_pending = awvalid && !awready;
  assign w_pending  = wvalid && !wready;

  // bready/rready are only ever high in WRESP/RDATA, so these handshakes
  // cannot fire in any other state.
  assign b_hs = bvalid && bready;
  assign r_hs = rvalid && rready;

  assign ram_ready = (state == IDLE);

  assign awid    = MID;
  assign arid    = MID;
  assign awlen   = '0;
  assign arlen   = '0;
  assign awsize  = AXSIZE;
  assign arsize  = AXSIZE;
  assign awburst = 2'b01;
  assign arburst = 2'b01;
  assign wlast   = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept_wr) state_nxt = WREQ;
               else if (accept_rd) state_nxt = RREQ;
      WREQ:    if (!aw_pending && !w_pending) state_nxt = WRESP;
      WRESP:   if (b_hs) state_nxt = IDLE;
      RREQ:    if (arvalid && arready) state_nxt = RDATA;
      RDATA:   if (r_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      arvalid    <= 1'b0;
      bready     <= 1'b0;
      rready     <= 1'b0;
      ram_rvalid <= 1'b0;
      ram_wdone  <= 1'b0;
      ram_err    <= 1'b0;
      ram_rdata  <= '0;
      awaddr     <= '0;
      araddr     <= '0;
      wdata      <= '0;
      wstrb      <= '0;
    end else begin
      // Ready strobes are registered from the next state so they are high
      // exactly for the cycles spent in the response states.
      bready     <= (state_nxt == WRESP);
      rready     <= (state_nxt == RDATA);
      ram_wdone  <= b_hs;
      ram_rvalid <= r_hs;
      ram_err    <= (b_hs && ((bresp != 2'b00) || (bid != MID))) ||
                    (r_hs && ((rresp != 2'b00) || (rid != MID) || !rlast));

      if (accept_wr) begin
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
        awaddr  <= ram_addr;
        wdata   <= ram_wdata;
        wstrb   <= ram_wstrb;
      end else begin
        if (awvalid && awready) awvalid <= 1'b0;
        if (wvalid && wready)   wvalid  <= 1'b0;
      end

      if (accept_rd) begin
        arvalid <= 1'b1;
        araddr  <= ram_addr;
      end else if (arvalid && arready) begin
        arvalid <= 1'b0;
      end

      if (r_hs) ram_rdata <= rdata;
    end
  end

endmodule

// File: tb/tb_ramif2axi.sv
// Testbench for ramif2axi: the bench plays the AXI slave with programmable
// ready/response delays and a byte-addressed word memory, while a separate
// reference memory built from the requested writes predicts read data.
module tb_ramif2axi;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int DW = 64;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ram_addr = '0;
  logic [DW-1:0] ram_wdata = '0;
  logic [SW-1:0] ram_wstrb = '0;
  logic          ram_wr = 1'b0;
  logic          ram_rd = 1'b0;
  logic          ram_ready;
  logic [DW-1:0] ram_rdata;
  logic          ram_rvalid, ram_wdone, ram_err;
  logic [IW-1:0] awid, arid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst;
  logic          awvalid, wvalid, wlast, arvalid, bready, rready;
  logic          awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic [IW-1:0] bid = '0, rid = '0;
  logic [1:0]    bresp = '0, rresp = '0;
  logic          bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [DW-1:0] rdata = '0;

  always #5 clk = ~clk;

  ramif2axi #(.AWID(AW), .IDWID(IW), .DWID(DW), .WSTRB(SW), .MASTER_ID(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
    .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_ready(ram_ready),
    .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid), .ram_wdone(ram_wdone), .ram_err(ram_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] ref_mem [logic [31:0]];
  logic [63:0] slv_mem [logic [31:0]];
  logic [63:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] dflt(input logic [31:0] a);
    return {~a, a};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [63:0] slv_read(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Idle cycles: no completion pulses, port ready, read data held.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_wdone", ram_wdone, 0);
      chk("idle_rvalid", ram_rvalid, 0);
      chk("idle_ready", ram_ready, 1);
      chk("rdata_hold", ram_rdata, exp_rdata);
    end
  endtask

  // Called at a negedge with the port idle (or with the request already
  // driven when pre=1); returns at the negedge of the ram_wdone cycle.
  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int awd, input int wd, input int bd,
                          input logic [1:0] br, input logic [3:0] bi,
                          input bit rd_too, input bit pre);
    int c;
    bit done_aw, done_w;
    if (!pre) begin
      chk("w_ready_idle", ram_ready, 1);
      ram_wr = 1'b1; ram_rd = rd_too; ram_addr = a; ram_wdata = d; ram_wstrb = s;
    end
    step();
    ram_wr = 1'b0; ram_rd = 1'b0;
    ram_addr = $urandom; ram_wdata = {$urandom, $urandom}; ram_wstrb = 8'($urandom);
    chk("w_busy", ram_ready, 0);
    chk("awaddr", awaddr, a);
    chk("awlen", awlen, 0);
    chk("awsize", awsize, 3);
    chk("awburst", awburst, 1);
    chk("awid", awid, 0);
    chk("wdata", wdata, d);
    chk("wstrb", wstrb, s);
    chk("wlast", wlast, 1);
    c = 0; done_aw = 0; done_w = 0;
    while (!(done_aw && done_w)) begin
      chk("awvalid", awvalid, c <= awd);
      chk("wvalid", wvalid, c <= wd);
      chk("arvalid_in_write", arvalid, 0);
      chk("bready_wreq", bready, 0);
      awready = (c >= awd);
      wready  = (c >= wd);
      if (wvalid && wready) slv_mem[awaddr] = merge(slv_read(awaddr), wdata, wstrb);
      // Stray responses before the response phase must be ignored.
      bvalid = 1'($urandom_range(0, 1)); bresp = 2'b10; bid = 4'hF;
      if (c == awd) done_aw = 1;
      if (c == wd)  done_w = 1;
      step();
      c++;
    end
    awready = 1'b0; wready = 1'b0;
    for (int k = 0; k <= bd; k++) begin
      chk("bready", bready, 1);
      chk("awvalid_resp", awvalid, 0);
      chk("wvalid_resp", wvalid, 0);
      chk("wdone_early", ram_wdone, 0);
      bvalid = (k == bd); bresp = br; bid = bi;
      step();
    end
    bvalid = 1'b0;
    chk("wdone", ram_wdone, 1);
    chk("w_err", ram_err, (br != 2'b00) || (bi != 4'h0));
    chk("w_ready_after", ram_ready, 1);
    chk("bready_off", bready, 0);
    ref_mem[a] = merge(ref_read(a), d, s);
  endtask

  // Returns at the negedge of the ram_rvalid cycle. With nxt=1 a write
  // request (ram_rd still high) is held for the whole read.
  task automatic do_read(input logic [31:0] a, input int ard, input int rdd,
                         input logic [1:0] rr, input logic [3:0] ri, input logic rl,
                         input bit nxt, input logic [31:0] wa, input logic [63:0] wd,
                         input logic [7:0] ws);
    logic [31:0] seen_addr;
    logic [63:0] expd;
    chk("r_ready_idle", ram_ready, 1);
    ram_rd = 1'b1; ram_wr = 1'b0; ram_addr = a;
    step();
    if (nxt) begin
      ram_wr = 1'b1; ram_addr = wa; ram_wdata = wd; ram_wstrb = ws;
    end else begin
      ram_rd = 1'b0; ram_addr = $urandom;
    end
    seen_addr = araddr;
    chk("r_busy", ram_ready, 0);
    chk("araddr", araddr, a);
    chk("arlen", arlen, 0);
    chk("arsize", arsize, 3);
    chk("arburst", arburst, 1);
    chk("arid", arid, 0);
    for (int c = 0; c <= ard; c++) begin
      chk("arvalid", arvalid, 1);
      chk("rready_rreq", rready, 0);
      chk("awvalid_in_read", awvalid, 0);
      arready = (c == ard);
      rvalid = 1'($urandom_range(0, 1)); rdata = {$urandom, $urandom};
      rresp = 2'b11; rid = 4'h5; rlast = 1'b0;
      step();
    end
    arready = 1'b0;
    expd = ref_read(a);
    for (int k = 0; k <= rdd; k++) begin
      chk("arvalid_drop", arvalid, 0);
      chk("rready", rready, 1);
      chk("rvalid_early", ram_rvalid, 0);
      rvalid = (k == rdd);
      rdata = (k == rdd) ? slv_read(seen_addr) : {$urandom, $urandom};
      rresp = rr; rid = ri; rlast = rl;
      step();
    end
    rvalid = 1'b0;
    chk("rvalid_pulse", ram_rvalid, 1);
    chk("ram_rdata", ram_rdata, expd);
    chk("r_err", ram_err, (rr != 2'b00) || (ri != 4'h0) || !rl);
    chk("r_ready_after", ram_ready, 1);
    chk("rready_off", rready, 0);
    exp_rdata = expd;
  endtask

  initial begin
    logic [31:0] a, a2;
    logic [63:0] d;
    logic [7:0]  s;

    repeat (3) @(negedge clk);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rvalid", ram_rvalid, 0);
    chk("rst_wdone", ram_wdone, 0);
    chk("rst_err", ram_err, 0);
    chk("rst_rdata", ram_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", ram_ready, 1);

    // Minimum-latency write, then the delayed-AW and delayed-W orders.
    do_write(32'h100, 64'hA5A5, 8'hFF, 0, 0, 0, 2'b00, 4'h0, 0, 0);
    idle(1);
    do_write(32'h108, 64'h1122334455667788, 8'h0F, 3, 0, 0, 2'b00, 4'h0, 0, 0);
    idle(1);
    do_write(32'h110, 64'hCAFEF00DDEADBEEF, 8'hF0, 0, 2, 1, 2'b00, 4'h0, 0, 0);
    idle(1);

    // Read with SLVERR data, then read-backs of earlier writes.
    slv_mem[32'h40] = 64'h1234;
    ref_mem[32'h40] = 64'h1234;
    do_read(32'h40, 0, 0, 2'b10, 4'h0, 1'b1, 0, '0, '0, '0);
    idle(2);
    do_read(32'h100, 2, 1, 2'b00, 4'h0, 1'b1, 0, '0, '0, '0);
    idle(1);
    do_read(32'h108, 0, 3, 2'b00, 4'h0, 1'b1, 0, '0, '0, '0);
    idle(1);

    // Response checks: wrong bid, missing rlast, wrong rid.
    do_write(32'h118, 64'h0, 8'h01, 1, 1, 0, 2'b00, 4'h3, 0, 0);
    idle(1);
    do_read(32'h110, 0, 0, 2'b00, 4'h0, 1'b0, 0, '0, '0, '0);
    idle(1);
    do_read(32'h110, 1, 0, 2'b00, 4'h2, 1'b1, 0, '0, '0, '0);
    idle(1);

    // Simultaneous write and read request: write only.
    do_write(32'h140, 64'h5555AAAA5555AAAA, 8'hFF, 1, 0, 0, 2'b00, 4'h0, 1, 0);
    idle(2);

    // Back-to-back read then write, both requests held high.
    do_read(32'h140, 0, 0, 2'b00, 4'h0, 1'b1, 1, 32'h148, 64'h0BADC0DE0BADC0DE, 8'hFF);
    do_write(32'h148, 64'h0BADC0DE0BADC0DE, 8'hFF, 0, 0, 0, 2'b00, 4'h0, 1, 1);
    idle(1);
    do_read(32'h148, 0, 0, 2'b00, 4'h0, 1'b1, 0, '0, '0, '0);
    idle(1);

    // Reset while waiting for read data.
    ram_rd = 1'b1; ram_addr = 32'h80;
    step();
    ram_rd = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0;
    chk("rst_mid_rready_before", rready, 1);
    rvalid = 1'b1; rdata = 64'hFFFF; rresp = 2'b00; rid = '0; rlast = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_rready", rready, 0);
    chk("rst_mid_ready", ram_ready, 1);
    chk("rst_mid_rdata", ram_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_rel_ready", ram_ready, 1);
      chk("rst_rel_rvalid", ram_rvalid, 0);
      chk("rst_rel_rready", rready, 0);
    end
    rvalid = 1'b0;
    chk("rst_rel_rdata", ram_rdata, 0);

    // Randomized mix against the reference memory.
    for (int t = 0; t < 60; t++) begin
      a  = 32'h200 + {$urandom_range(0, 15), 3'b000};
      a2 = 32'h200 + {$urandom_range(0, 15), 3'b000};
      d  = {$urandom, $urandom};
      s  = 8'($urandom);
      case ($urandom_range(0, 4))
        0, 1: do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3),
                       ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                       ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                       1'($urandom_range(0, 1)), 0);
        2, 3: do_read(a, $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                      ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                      ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1, 0, '0, '0, '0);
        default: begin
          do_read(a, $urandom_range(0, 2), $urandom_range(0, 2), 2'b00, 4'h0, 1'b1,
                  1, a2, d, s);
          do_write(a2, d, s, $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 2), 2'b00, 4'h0, 1, 1);
        end
      endcase
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
